// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions: FSM state encodings, default polynomial/init, one-bit LFSR step.
package crc8_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
  localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

  // One MSB-first, non-reflected LFSR step with the x^8 term implicit.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                           input logic       din,
                                           input logic [7:0] poly);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_lfsr_step.sv
// Combinational CRC-8 update over N data bits, data[N-1] applied first.
module crc8_lfsr_step
  import crc8_pkg::*;
#(
  parameter int         N    = 1,
  parameter logic [7:0] POLY = CRC8_POLY_DEFAULT
) (
  input  logic [7:0]   crc_in,
  input  logic [N-1:0] data,
  output logic [7:0]   crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in;
    for (int i = N - 1; i >= 0; i--) begin
      c = crc8_step(c, data[i], POLY);
    end
    crc_out = c;
  end

endmodule

// File: rtl/crc8_frame_check.sv
// Framed CRC-8 checker: last byte of each frame is the expected CRC of the preceding payload.
// Bit-serial by default (1 byte / 9 cycles); define CRC8_FRAME_PARALLEL_EN for 1 byte / cycle.
module crc8_frame_check
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY    = CRC8_POLY_DEFAULT,
  parameter logic [7:0] INIT    = CRC8_INIT_DEFAULT,
  parameter int         MAX_LEN = 255,
  localparam int        CW      = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [7:0]    crc_out,
  output logic          frame_done,
  output logic          frame_ok,
  output logic          len_err,
  output logic [CW-1:0] byte_count
);

  logic [1:0]    state;
  logic [7:0]    crc_reg;
  logic [7:0]    crc_next;
  logic          ovf;
  logic          new_frame;
  logic          accept;
  logic [CW-1:0] cnt_base;
  logic [CW-1:0] cnt_inc;
  logic          ovf_next;
  logic          len_now;

  assign in_ready = (state == ST_IDLE) & ~rst;
  assign accept   = in_valid & in_ready;

`ifdef CRC8_FRAME_PARALLEL_EN
  crc8_lfsr_step #(.N(8), .POLY(POLY)) u_step (
    .crc_in  (crc_reg),
    .data    (in_data),
    .crc_out (crc_next)
  );
`else
  logic [7:0] shreg;
  logic [2:0] bit_cnt;

  crc8_lfsr_step #(.N(1), .POLY(POLY)) u_step (
    .crc_in  (crc_reg),
    .data    (shreg[bit_cnt]),
    .crc_out (crc_next)
  );
`endif

  // byte_count of the previous frame stays visible until the next frame's first byte.
  always_comb begin
    cnt_base = new_frame ? '0 : byte_count;
    cnt_inc  = (cnt_base == CW'(MAX_LEN)) ? cnt_base : cnt_base + 1'b1;
    ovf_next = (new_frame ? 1'b0 : ovf) | (cnt_base == CW'(MAX_LEN));
    len_now  = (cnt_base == '0) | ovf_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      crc_reg    <= INIT;
      byte_count <= '0;
      ovf        <= 1'b0;
      new_frame  <= 1'b1;
      crc_out    <= 8'h00;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      len_err    <= 1'b0;
`ifndef CRC8_FRAME_PARALLEL_EN
      shreg      <= 8'h00;
      bit_cnt    <= 3'd0;
`endif
    end else if (clr) begin
      state      <= ST_IDLE;
      crc_reg    <= INIT;
      byte_count <= '0;
      ovf        <= 1'b0;
      new_frame  <= 1'b1;
      frame_done <= 1'b0;
`ifndef CRC8_FRAME_PARALLEL_EN
      bit_cnt    <= 3'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            byte_count <= cnt_inc;
            ovf        <= ovf_next;
            new_frame  <= 1'b0;
            if (in_last) begin
              state      <= ST_DONE;
              frame_done <= 1'b1;
              crc_out    <= crc_reg;
              len_err    <= len_now;
              frame_ok   <= (crc_reg == in_data) & ~len_now;
            end else begin
`ifdef CRC8_FRAME_PARALLEL_EN
              crc_reg <= crc_next;
`else
              shreg   <= in_data;
              bit_cnt <= 3'd7;
              state   <= ST_SHIFT;
`endif
            end
          end
        end
`ifndef CRC8_FRAME_PARALLEL_EN
        ST_SHIFT: begin
          crc_reg <= crc_next;
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) state <= ST_IDLE;
        end
`endif
        ST_DONE: begin
          crc_reg   <= INIT;
          new_frame <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc8_frame_check.sv
// Directed bench for crc8_frame_check (bit-serial build); a MAX_LEN=4 instance shares the stimulus.
module tb_crc8_frame_check;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] crc_out;
  logic       frame_done;
  logic       frame_ok;
  logic       len_err;
  logic [7:0] byte_count;

  logic       in_ready4;
  logic [7:0] crc_out4;
  logic       frame_done4;
  logic       frame_ok4;
  logic       len_err4;
  logic [2:0] byte_count4;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int acc_cnt = 0;
  logic [7:0] fq[$];

  always #5 clk = ~clk;

  crc8_frame_check dut (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready), .crc_out(crc_out), .frame_done(frame_done),
    .frame_ok(frame_ok), .len_err(len_err), .byte_count(byte_count)
  );

  crc8_frame_check #(.MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst), .clr(clr), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(in_ready4), .crc_out(crc_out4), .frame_done(frame_done4),
    .frame_ok(frame_ok4), .len_err(len_err4), .byte_count(byte_count4)
  );

  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (in_valid && in_ready) acc_cnt++;
  end

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = l;
    while (!in_ready && n < 40) begin @(posedge clk); #1; n++; end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 40 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
    foreach (fq[i]) send_byte(fq[i], i == fq.size() - 1);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!frame_done && n < 40) begin @(posedge clk); #1; n++; end
    checks++;
    if (!frame_done) begin
      errors++;
      $display("FAIL %s_done_timeout: got frame_done=0 expected 1", name);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_crc_out", crc_out, 8'h00);
    chk("rst_frame_ok", frame_ok, 0);
    chk("rst_len_err", len_err, 0);
    chk("rst_byte_count", byte_count, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_release_ready", in_ready, 1);
  endtask

  task automatic test_nominal();
    fq = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39, 8'hF4};
    send_frame();
    wait_done("nominal");
    chk("nominal_crc_out", crc_out, 8'hF4);
    chk("nominal_frame_ok", frame_ok, 1);
    chk("nominal_len_err", len_err, 0);
    chk("nominal_byte_count", byte_count, 10);
    chk("nominal_ready_in_done", in_ready, 0);
    @(posedge clk); #1;
    chk("nominal_done_pulse", frame_done, 0);
    chk("nominal_ok_held", frame_ok, 1);
  endtask

  task automatic test_mismatch();
    fq = '{8'h01, 8'h06};
    send_frame();
    wait_done("mismatch");
    chk("mismatch_crc_out", crc_out, 8'h07);
    chk("mismatch_frame_ok", frame_ok, 0);
    chk("mismatch_len_err", len_err, 0);
    chk("mismatch_byte_count", byte_count, 2);
    @(posedge clk); #1;
  endtask

  task automatic test_single_byte();
    fq = '{8'h00};
    send_frame();
    wait_done("single");
    chk("single_len_err", len_err, 1);
    chk("single_frame_ok", frame_ok, 0);
    chk("single_crc_out", crc_out, 8'h00);
    chk("single_byte_count", byte_count, 1);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int low = 0;
    int acc0;
    acc0 = acc_cnt;
    in_valid = 1'b1; in_data = 8'h01; in_last = 1'b0;
    @(posedge clk); #1;
    in_data = 8'h07; in_last = 1'b1;
    while (!in_ready && low < 20) begin low++; @(posedge clk); #1; end
    chk("b2b_ready_low_cycles", low, 8);
    @(posedge clk); #1;
    chk("b2b_frame_done", frame_done, 1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("b2b_frame_ok", frame_ok, 1);
    chk("b2b_crc_out", crc_out, 8'h07);
    chk("b2b_accept_count", acc_cnt - acc0, 2);
  endtask

  task automatic test_clr();
    int d0;
    send_byte(8'h55, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    d0 = done_cnt;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    chk("clr_ready", in_ready, 1);
    chk("clr_byte_count", byte_count, 0);
    chk("clr_ok_held", frame_ok, 1);
    chk("clr_crc_held", crc_out, 8'h07);
    repeat (12) @(posedge clk);
    #1;
    chk("clr_no_done", done_cnt - d0, 0);
    fq = '{8'h00, 8'h00};
    send_frame();
    wait_done("clr_next");
    chk("clr_next_ok", frame_ok, 1);
    chk("clr_next_crc", crc_out, 8'h00);
    chk("clr_next_count", byte_count, 2);
    @(posedge clk); #1;
  endtask

  task automatic test_overlength();
    fq = '{8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_done("maxlen");
    chk("maxlen_done4", frame_done4, 1);
    chk("maxlen_count4", byte_count4, 4);
    chk("maxlen_len_err4", len_err4, 0);
    chk("maxlen_ok4", frame_ok4, 1);
    @(posedge clk); #1;
    fq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    send_frame();
    wait_done("over");
    chk("over_count4", byte_count4, 4);
    chk("over_len_err4", len_err4, 1);
    chk("over_ok4", frame_ok4, 0);
    chk("over_count_wide", byte_count, 6);
    chk("over_ok_wide", frame_ok, 1);
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    send_byte(8'hAA, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_in_ready", in_ready, 0);
    chk("arst_byte_count", byte_count, 0);
    chk("arst_crc_out", crc_out, 8'h00);
    chk("arst_frame_ok", frame_ok, 0);
    chk("arst_len_err", len_err, 0);
    chk("arst_frame_done", frame_done, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("arst_release_ready", in_ready, 1);
    fq = '{8'h01, 8'h07};
    send_frame();
    wait_done("arst_next");
    chk("arst_next_ok", frame_ok, 1);
    chk("arst_next_count", byte_count, 2);
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mismatch();
    test_single_byte();
    test_back_to_back();
    test_clr();
    test_overlength();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc8_frame_check.md
Name: crc8_frame_check

Overview:
- Byte-stream front end for CRC-8 checking.
- Accepts framed bytes over a valid/ready handshake and runs each payload byte bit-serially, MSB first, through a CRC-8 LFSR.
- Treats the final byte of each frame as the transmitted CRC and reports pass/fail plus the computed CRC.
- Sits between the byte receiver and packet consumers; backpressures the receiver while shifting.

Parameters:
POLY, 8'h07, CRC-8 generator polynomial (x^8 implicit); non-reflected, no output XOR
INIT, 8'h00, CRC register value at frame start
MAX_LEN, 255, maximum frame length in bytes including CRC byte; sets width of byte_count (clog2(MAX_LEN+1))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
clr  in  1  synchronous abort: drop current frame, return to IDLE
in_data  in  8  stream byte
in_valid  in  1  in_data valid
in_last  in  1  qualifies in_data as final (CRC) byte of frame
in_ready  out  1  block can accept a byte this cycle
crc_out  out  8  CRC computed over payload bytes (all but last); held until next frame_done
frame_done  out  1  one-cycle pulse: frame verdict valid
frame_ok  out  1  valid with frame_done: crc match and length legal; held
len_err  out  1  valid with frame_done: length <2 or >MAX_LEN; held
byte_count  out  clog2(MAX_LEN+1)  bytes accepted in current/last frame, saturating at MAX_LEN

Behaviour:
- Reset (rst high, async): state IDLE, crc reg=INIT, bit counter=0, byte_count=0, in_ready=0 during reset then 1, crc_out=8'h00, frame_done=0, frame_ok=0, len_err=0.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready.
  - Non-last byte: latch byte, increment byte_count (saturating), go SHIFT, bit counter=7.
  - Last byte: compare against crc reg, go DONE.
- SHIFT: in_ready=0. Each cycle: fb = crc[7]^byte[counter]; crc = {crc[6:0],1'b0} ^ (fb ? POLY : 0). Counter decrements 7..0. After bit 0, return to IDLE.
- Latency: a byte accepted at edge T is shifted on edges T+1..T+8; in_ready high in the cycle after T+8. Throughput is 1 byte per 9 cycles.
- DONE: single cycle.
  - frame_done=1.
  - crc_out = crc reg (payload CRC).
  - len_err = (byte_count_incl_last < 2) || overflow, where overflow is set when a byte arrives with byte_count already at MAX_LEN.
  - frame_ok = (crc reg == last byte) && !len_err.
  - crc reg reset to INIT, byte_count cleared on the next accepted byte. Next state IDLE; in_ready=0 in DONE.
- Single-byte frame (in_last on first byte): comparison is against INIT, len_err=1, frame_ok=0.
- Overlength: bytes still accepted and shifted; byte_count saturates; len_err=1 at end.
- clr: from any state, next cycle is IDLE with crc reg=INIT, byte_count=0. No frame_done pulse. Verdict outputs are held. clr has priority over acceptance in the same cycle.
- rst mid-frame: immediate return to reset values; partial frame is discarded.
- in_data/in_last are ignored while in_ready=0. The upstream source must hold them stable until acceptance.

Optional Feature:
- Macro CRC8_FRAME_PARALLEL_EN.
- Defined: byte-parallel update (8 unrolled LFSR steps in one cycle). SHIFT state is removed and in_ready stays 1 except in DONE, giving 1 byte/cycle. A payload byte accepted at T is reflected in the crc reg after edge T.
- Undefined: bit-serial behaviour as above.
- Verdicts are identical in both builds.

Decomposition:
- crc8_pkg holds:
  - state enum (IDLE/SHIFT/DONE)
  - default POLY/INIT constants
  - a crc8_step function (one-bit update) shared with the existing CRC engine
- One sub-module, crc8_lfsr_step: combinational 1-bit or N-bit unrolled update. It is instantiated once serially, or with N=8 in the parallel build.

Test Plan:
- Frame 0x31..0x39 then last 0xF4 -> frame_done after 10th accept, crc_out=0xF4, frame_ok=1, len_err=0, byte_count=10.
- Frame {0x01, last 0x06} -> crc_out=0x07, frame_ok=0, len_err=0.
- Single byte 0x00 with in_last -> frame_done, len_err=1, frame_ok=0, crc_out=0x00.
- in_valid held high continuously for frame {0x01, 0x07} -> in_ready low exactly 8 cycles after first accept, frame_ok=1; each byte accepted once.
- clr asserted mid-SHIFT of frame 2, then frame {0x00, 0x00} -> no frame_done for aborted frame; next verdict frame_ok=1, crc_out=0x00.
- MAX_LEN=4, frame of 6 bytes -> byte_count=4, len_err=1, frame_ok=0; async rst pulse mid-frame -> all outputs at reset values within the same cycle.
